// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory and its response FIFO.
package mem_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int RSP_FIFO_DEPTH = 2;

    // One response as queued towards the requester.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Two-entry response FIFO with 1-bit wrapping pointers; head is always visible on dout.
module rsp_fifo
    import mem_pkg::*;
#(
    parameter type T = mem_rsp_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  T           din,
    output T           dout,
    output logic [1:0] count
);

    localparam logic [1:0] FULL_COUNT = 2'(RSP_FIFO_DEPTH);

    T           entries_r [RSP_FIFO_DEPTH];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       push_ok_s;
    logic       pop_ok_s;

    // Ignore pushes into a full FIFO and pops from an empty one.
    always_comb begin
        push_ok_s = push & (count_r != FULL_COUNT);
        pop_ok_s  = pop  & (count_r != 2'd0);
    end

    // Entry storage; cleared on reset so the head reads as zero while idle in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            entries_r[wr_ptr_r] <= din;
        end else begin
            entries_r[wr_ptr_r] <= entries_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 1 bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = entries_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte-enable stores, address checking and a
// two-deep response FIFO providing valid/ready flow control on both sides.
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic          req_ready_r;
    logic          rsp_valid_r;
    logic          push_s;
    logic          pop_s;
    logic [29:0]   word_addr_s;
    logic [AW-1:0] word_idx_s;
    logic          addr_err_s;
    logic [1:0]    fifo_count_s;
    logic [1:0]    count_next_s;
    mem_rsp_t      rsp_s;
    mem_rsp_t      head_s;

    // Handshakes, address check, response formation and next FIFO occupancy.
    always_comb begin
        push_s      = req_valid & req_ready_r;
        pop_s       = rsp_valid_r & rsp_ready;
        word_addr_s = req_addr[31:2];
        word_idx_s  = req_addr[AW+1:2];
        addr_err_s  = (req_addr[1:0] != 2'b00) ||
                      ({2'b00, word_addr_s} >= 32'(DEPTH_WORDS));
        rsp_s       = '0;
        if (addr_err_s) begin
            rsp_s.rdata = 32'h0000_0000;
            rsp_s.err   = 1'b1;
        end else if (req_we) begin
            rsp_s.rdata = 32'h0000_0000;
            rsp_s.err   = 1'b0;
        end else begin
            rsp_s.rdata = mem_r[word_idx_s];
            rsp_s.err   = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = fifo_count_s + 2'd1;
            2'b01:   count_next_s = fifo_count_s - 2'd1;
            default: count_next_s = fifo_count_s;
        endcase
    end

    // Storage array: byte-merged write on an accepted, in-range store; not reset.
    always_ff @(posedge clk) begin
        if (push_s && req_we && !addr_err_s) begin
            mem_r[word_idx_s] <= merge_bytes(mem_r[word_idx_s], req_wdata, req_be);
        end
    end

    // Registered flow-control flags derived from the occupancy after this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (count_next_s < 2'(RSP_FIFO_DEPTH));
            rsp_valid_r <= (count_next_s != 2'd0);
        end
    end

    rsp_fifo #(
        .T (mem_rsp_t)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (rsp_s),
        .dout  (head_s),
        .count (fifo_count_s)
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = head_s.rdata;
    assign rsp_err   = head_s.err;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: behavioural model plus directed literal checks.
module tb_data_memory;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] mdl_mem [int];
    logic [32:0] exp_q [$];
    logic [32:0] got_q [$];
    logic        ready_m = 1'b0;

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected response for a request, from address rules and the model memory.
    function automatic logic [32:0] model_rsp(input logic [31:0] a, input logic we,
                                              input logic [3:0] be, input logic [31:0] d);
        int unsigned w;
        logic [31:0] v;
        w = a >> 2;
        if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) return {32'h0, 1'b1};
        if (we) begin
            v = mdl_mem.exists(w) ? mdl_mem[w] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
            mdl_mem[w] = v;
            return {32'h0, 1'b0};
        end
        if (!mdl_mem.exists(w)) $display("note: load of unwritten word %0d", w);
        return {mdl_mem[w], 1'b0};
    endfunction

    // Model update on each edge: pop old head, then accept a new request.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            ready_m = 1'b0;
        end else begin
            if (exp_q.size() > 0 && rsp_ready) void'(exp_q.pop_front());
            if (ready_m && req_valid) exp_q.push_back(model_rsp(req_addr, req_we, req_be, req_wdata));
            ready_m = (exp_q.size() < 2);
        end
    end

    // Compare DUT outputs against the model every cycle; log delivered responses.
    always @(negedge clk) begin
        chk("req_ready", {31'h0, req_ready}, {31'h0, ready_m});
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, (exp_q.size() != 0)});
        if (exp_q.size() != 0) begin
            chk("rsp_rdata", rsp_rdata, exp_q[0][32:1]);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_q[0][0]});
        end else if (!rst) begin
            chk("rst_rdata", rsp_rdata, 32'h0);
            chk("rst_err", {31'h0, rsp_err}, 32'h0);
        end
        if (rsp_valid && rsp_ready) got_q.push_back({rsp_rdata, rsp_err});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
        int n;
        logic acc;
        n = 0;
        req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wdata = d;
        do begin
            acc = req_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance for addr %h", a);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic got(input int idx, input logic [31:0] rd, input logic er);
        checks++;
        if (got_q.size() <= idx) begin
            errors++;
            $display("FAIL got_count: got %0d responses expected more than %0d", got_q.size(), idx);
        end else if (got_q[idx] !== {rd, er}) begin
            errors++;
            $display("FAIL got_rsp%0d: got %h/%b expected %h/%b", idx, got_q[idx][32:1], got_q[idx][0], rd, er);
        end
    endtask

    initial begin
        logic [31:0] a;
        int sel;

        // Reset held for 3 cycles, then released mid-cycle
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Store then load
        rsp_ready = 1'b1;
        got_q.delete();
        send(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        send(32'h10, 1'b0, 4'h0, 32'h0);
        drain();
        got(0, 32'h0, 1'b0);
        got(1, 32'hDEADBEEF, 1'b0);

        // Partial store
        got_q.delete();
        send(32'h20, 1'b1, 4'hF, 32'h11223344);
        send(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
        send(32'h20, 1'b0, 4'h0, 32'h0);
        drain();
        got(2, 32'h11BB33DD, 1'b0);

        // Errors, zero-enable store, unaffected load
        got_q.delete();
        send(32'h13, 1'b0, 4'h0, 32'h0);
        send(32'h1000, 1'b0, 4'h0, 32'h0);
        send(32'h1000, 1'b1, 4'hF, 32'h12345678);
        send(32'h10, 1'b1, 4'h0, 32'hFFFFFFFF);
        send(32'h10, 1'b0, 4'h0, 32'h0);
        drain();
        got(0, 32'h0, 1'b1);
        got(1, 32'h0, 1'b1);
        got(2, 32'h0, 1'b1);
        got(3, 32'h0, 1'b0);
        got(4, 32'hDEADBEEF, 1'b0);

        // Backpressure: two accepted, third stalls with stable head
        got_q.delete();
        rsp_ready = 1'b0;
        send(32'h10, 1'b0, 4'h0, 32'h0);
        send(32'h20, 1'b0, 4'h0, 32'h0);
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", {31'h0, req_ready}, 32'h0);
            chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
            tick();
        end
        rsp_ready = 1'b1;
        send(32'h10, 1'b0, 4'h0, 32'h0);
        drain();
        got(0, 32'hDEADBEEF, 1'b0);
        got(1, 32'h11BB33DD, 1'b0);
        got(2, 32'hDEADBEEF, 1'b0);

        // Reset with two responses queued
        got_q.delete();
        rsp_ready = 1'b0;
        send(32'h10, 1'b0, 4'h0, 32'h0);
        send(32'h20, 1'b0, 4'h0, 32'h0);
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'h0, rsp_valid}, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        drain();
        chk("midrst_stale", got_q.size(), 32'h0);

        // Randomised traffic over an initialised window of words 32..47
        for (int w = 32; w < 48; w++) send(w * 4, 1'b1, 4'hF, $urandom);
        drain();
        for (int c = 0; c < 3000; c++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = (32 + $urandom_range(0, 15)) * 4;
            else if (sel < 9) a = (32 + $urandom_range(0, 15)) * 4 + $urandom_range(1, 3);
            else              a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr  = a;
            req_we    = $urandom_range(0, 1);
            req_be    = 4'($urandom_range(0, 15));
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the store (power of two, 4 to 65536).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, asynchronous and active-low: asserted when 0, independent of clk.
REQ-004 The module SHALL have port req_valid, input, 1, meaning the requester offers a request this cycle.
REQ-005 The module SHALL have port req_ready, output, 1, meaning the module accepts a request this cycle.
REQ-006 The module SHALL have port req_addr, input, 32, the byte address.
REQ-007 The module SHALL have port req_we, input, 1, with 1 = store and 0 = load.
REQ-008 The module SHALL have port req_be, input, 4, the store byte enables, where bit i covers wdata[8i+7:8i].
REQ-009 The module SHALL have port req_wdata, input, 32, the store data.
REQ-010 The module SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-011 The module SHALL have port rsp_ready, input, 1, meaning the requester takes the response.
REQ-012 The module SHALL have port rsp_rdata, output, 32, the load data (0 for stores and errors).
REQ-013 The module SHALL have port rsp_err, output, 1, meaning the request was misaligned or out of range.

Function
REQ-014 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; a response SHALL be accepted on a rising edge where rsp_valid and rsp_ready are both 1.
REQ-015 The module SHALL produce exactly one response per accepted request, in acceptance order.
REQ-016 Responses SHALL pass through a 2-entry response FIFO.
REQ-017 req_ready SHALL be 1 exactly when FIFO occupancy < 2, registered, with no combinational path from rsp_ready.
REQ-018 On acceptance the module SHALL compute the response and write it into the FIFO on the same edge, so rsp_valid rises the next cycle (latency 1 when the FIFO is empty).
REQ-019 The module SHALL flag an error when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS.
REQ-020 An erroring request SHALL leave memory unchanged and produce a response with rsp_err=1 and rsp_rdata=0.
REQ-021 A valid load SHALL produce a response with rsp_rdata equal to mem[req_addr[31:2]] and rsp_err=0.
REQ-022 A valid store SHALL update only the bytes selected by req_be, and SHALL produce a response with rsp_rdata=0 and rsp_err=0.
REQ-023 A store with req_be=0 SHALL succeed and change nothing.
REQ-024 A load accepted the cycle after a store to the same word SHALL return the post-store value.
REQ-025 When the FIFO is full (occupancy 2), the module SHALL hold req_ready=0.
REQ-026 When the FIFO is full and a response handshake occurs, the FIFO SHALL drop to occupancy 1 and req_ready SHALL rise the next cycle.
REQ-027 On a simultaneous push and pop, occupancy SHALL be unchanged and ordering SHALL be preserved.
REQ-028 While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err SHALL hold stable.
REQ-029 FIFO read and write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-030 Acceptance while req_valid=0 SHALL have no effect.

Reset
REQ-031 While rst=0, the module SHALL drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear the FIFO occupancy and pointers, and accept no request.
REQ-032 On the first rising clk edge after rst rises, req_ready SHALL become 1.
REQ-033 Memory array contents SHALL be unaffected by reset.
REQ-034 Responses in flight when reset asserts mid-operation SHALL be discarded.
REQ-035 A store accepted on the same edge as reset assertion SHALL not be guaranteed.

Structure
REQ-036 A shared package mem_pkg SHALL hold the mem_rsp_t typedef (rdata[31:0], err), the constant WORD_BYTES=4, and the constant RSP_FIFO_DEPTH=2.
REQ-037 The FIFO SHALL be implemented as a single sub-module, rsp_fifo, parameterised on mem_rsp_t, with ports clk, rst, push, pop, din, dout, count.
REQ-038 The storage array SHALL be inferred inside data_memory.

Verification
REQ-039 The bench SHALL cover reset: hold rst=0 for 3 cycles, then release -> rsp_valid=0 throughout; req_ready=1 at the first edge after release.
REQ-040 The bench SHALL cover store then load: store addr 0x10, be=4'b1111, wdata 0xDEADBEEF; next cycle load 0x10 -> store response (0, err 0), then load response 0xDEADBEEF.
REQ-041 The bench SHALL cover a partial store: memory at 0x20 = 0x11223344; store be=4'b0101, wdata 0xAABBCCDD -> load 0x20 returns 0x11BB33DD.
REQ-042 The bench SHALL cover errors: load 0x13, then load at 4*DEPTH_WORDS -> both responses err=1, rdata=0; a following load of 0x10 is unaffected.
REQ-043 The bench SHALL cover backpressure: rsp_ready=0 with 3 back-to-back loads -> 2 accepted, req_ready=0; release rsp_ready -> all 3 responses return in order with data stable while stalled.
REQ-044 The bench SHALL cover reset mid-operation: assert rst with 2 responses queued -> rsp_valid=0 immediately; after release, no stale responses appear.
